// File: rtl/fir_coef_loader.sv
// Stages a burst of NUM_TAPS coefficients in a shadow bank and commits them atomically to the tap weight bus.
// Optional build macro FIR_COEF_REVERSE_EN: beat j lands in tap NUM_TAPS-1-j instead of tap j.
module fir_coef_loader #(
    parameter int DATA_WIDTH = 24,
    parameter int NUM_TAPS   = 8,
    parameter int IDX_WIDTH  = 3
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_start,
    input  logic                           i_abort,
    input  logic [DATA_WIDTH-1:0]          iv_coef,
    input  logic                           i_coef_valid,
    output logic                           o_coef_ready,
    output logic                           o_busy,
    output logic                           o_done,
    output logic                           o_weights_valid,
    output logic [DATA_WIDTH*NUM_TAPS-1:0] ov_weights
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_TAPS - 1);

    state_t                 state_reg, state_next;
    logic [IDX_WIDTH-1:0]   idx_reg, idx_next;
    logic [IDX_WIDTH-1:0]   wr_addr;
    logic                   beat_accept;
    logic                   commit;
    logic                   coef_ready_reg;
    logic                   busy_reg;
    logic                   done_reg;
    logic                   weights_valid_reg;
    logic [DATA_WIDTH-1:0]  shadow_reg  [NUM_TAPS];
    logic [DATA_WIDTH-1:0]  weights_reg [NUM_TAPS];

    // Abort wins over a simultaneous beat, so that beat is never written.
    assign beat_accept = (state_reg == LOAD) && i_coef_valid && !i_abort;
    assign commit      = (state_reg == COMMIT);

`ifdef FIR_COEF_REVERSE_EN
    assign wr_addr = LAST_IDX - idx_reg;
`else
    assign wr_addr = idx_reg;
`endif

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        unique case (state_reg)
            IDLE: begin
                if (i_start) begin
                    state_next = LOAD;
                    idx_next   = '0;
                end
            end
            LOAD: begin
                if (i_abort) begin
                    state_next = IDLE;
                    idx_next   = '0;
                end else if (beat_accept) begin
                    if (idx_reg == LAST_IDX) begin
                        state_next = COMMIT;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
            end
            COMMIT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
    end

    // Handshake/status outputs are registered from the next state so they track the state register exactly.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg         <= IDLE;
            idx_reg           <= '0;
            coef_ready_reg    <= 1'b0;
            busy_reg          <= 1'b0;
            done_reg          <= 1'b0;
            weights_valid_reg <= 1'b0;
        end else begin
            state_reg         <= state_next;
            idx_reg           <= idx_next;
            coef_ready_reg    <= (state_next == LOAD);
            busy_reg          <= (state_next != IDLE);
            done_reg          <= commit;
            weights_valid_reg <= weights_valid_reg | commit;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_tap
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    shadow_reg[gi] <= '0;
                end else if (beat_accept && (wr_addr == IDX_WIDTH'(gi))) begin
                    shadow_reg[gi] <= iv_coef;
                end
            end

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    weights_reg[gi] <= '0;
                end else if (commit) begin
                    weights_reg[gi] <= shadow_reg[gi];
                end
            end

            assign ov_weights[gi*DATA_WIDTH +: DATA_WIDTH] = weights_reg[gi];
        end
    endgenerate

    assign o_coef_ready    = coef_ready_reg;
    assign o_busy          = busy_reg;
    assign o_done          = done_reg;
    assign o_weights_valid = weights_valid_reg;

endmodule

// File: tb/tb_fir_coef_loader.sv
// Directed bench for fir_coef_loader: reset, back-to-back, gapped, abort and reset-mid-load bursts.
module tb_fir_coef_loader;

    localparam int DW = 24;
    localparam int NT = 8;
    localparam int W  = DW * NT;

    logic          i_clk;
    logic          i_rst;
    logic          i_start;
    logic          i_abort;
    logic [DW-1:0] iv_coef;
    logic          i_coef_valid;
    logic          o_coef_ready;
    logic          o_busy;
    logic          o_done;
    logic          o_weights_valid;
    logic [W-1:0]  ov_weights;

    int checks;
    int failures;

    logic [DW-1:0] beats [NT];
    logic [W-1:0]  exp_weights;

    fir_coef_loader #(
        .DATA_WIDTH(DW),
        .NUM_TAPS  (NT),
        .IDX_WIDTH (3)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_start        (i_start),
        .i_abort        (i_abort),
        .iv_coef        (iv_coef),
        .i_coef_valid   (i_coef_valid),
        .o_coef_ready   (o_coef_ready),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_weights_valid(o_weights_valid),
        .ov_weights     (ov_weights)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Expected bus after committing beats[]: tap k gets beat k, or beat NT-1-k in the reversed build.
    function automatic logic [W-1:0] packed_beats();
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < NT; k++) begin
`ifdef FIR_COEF_REVERSE_EN
            r[k*DW +: DW] = beats[NT-1-k];
`else
            r[k*DW +: DW] = beats[k];
`endif
        end
        return r;
    endfunction

    // Full burst from beats[]; gap inserts an idle cycle between beats. Checks timing and the commit.
    task automatic run_burst(input string name, input bit gap);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        check({name, " ready_after_start"}, W'(o_coef_ready), W'(1));
        for (int j = 0; j < NT; j++) begin
            if (gap && j > 0) begin
                i_coef_valid = 1'b0;
                step();
                check({name, " weights_held_in_gap"}, ov_weights, exp_weights);
            end
            i_coef_valid = 1'b1;
            iv_coef      = beats[j];
            step();
        end
        i_coef_valid = 1'b0;
        check({name, " commit_ready_low"}, W'(o_coef_ready), W'(0));
        check({name, " commit_busy"}, W'(o_busy), W'(1));
        check({name, " commit_no_done"}, W'(o_done), W'(0));
        check({name, " commit_old_weights"}, ov_weights, exp_weights);
        step();
        exp_weights = packed_beats();
        check({name, " done_pulse"}, W'(o_done), W'(1));
        check({name, " weights"}, ov_weights, exp_weights);
        check({name, " weights_valid"}, W'(o_weights_valid), W'(1));
        check({name, " idle_busy"}, W'(o_busy), W'(0));
        step();
        check({name, " done_single"}, W'(o_done), W'(0));
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        i_rst        = 1'b0;
        i_start      = 1'b0;
        i_abort      = 1'b0;
        iv_coef      = '0;
        i_coef_valid = 1'b0;
        exp_weights  = '0;

        // Test 1: reset asserted mid-cycle, outputs clear at once
        #3;
        i_rst = 1'b1;
        #1;
        check("rst ready", W'(o_coef_ready), W'(0));
        check("rst busy", W'(o_busy), W'(0));
        check("rst done", W'(o_done), W'(0));
        check("rst wvalid", W'(o_weights_valid), W'(0));
        check("rst weights", ov_weights, '0);
        step();
        step();
        i_rst = 1'b0;
        i_coef_valid = 1'b1;
        iv_coef = 24'h00ABCD;
        for (int c = 0; c < 3; c++) begin
            step();
            check("idle ready_stays_low", W'(o_coef_ready), W'(0));
            check("idle busy", W'(o_busy), W'(0));
        end
        i_coef_valid = 1'b0;
        check("idle beats_ignored", ov_weights, '0);

        // Test 2 (and test 6 in the reversed build): back-to-back 1..8
        for (int k = 0; k < NT; k++) beats[k] = DW'(k + 1);
        run_burst("b2b", 1'b0);

        // Test 3: gapped, extreme bit patterns
        beats[0] = 24'hFFFFFF; beats[1] = 24'h7FFFFF; beats[2] = 24'h800000; beats[3] = 24'h000001;
        beats[4] = 24'h123456; beats[5] = 24'hABCDEF; beats[6] = 24'h800001; beats[7] = 24'h7FFFFE;
        run_burst("gap", 1'b1);

        // Test 4: abort with the 6th beat
        for (int k = 0; k < NT; k++) beats[k] = DW'(k + 1);
        run_burst("pre_abort", 1'b0);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        i_coef_valid = 1'b1;
        iv_coef = 24'h000100;
        for (int j = 0; j < 5; j++) step();
        i_abort = 1'b1;
        check("abort ready_masked", W'(o_coef_ready), W'(1));
        step();
        i_abort = 1'b0;
        i_coef_valid = 1'b0;
        check("abort idle_busy", W'(o_busy), W'(0));
        check("abort ready_low", W'(o_coef_ready), W'(0));
        check("abort no_done", W'(o_done), W'(0));
        step();
        check("abort no_done_late", W'(o_done), W'(0));
        check("abort weights_kept", ov_weights, exp_weights);
        for (int k = 0; k < NT; k++) beats[k] = DW'(24'h55 + k);
        run_burst("post_abort", 1'b0);

        // Test 5: reset after 3 beats of a new burst
        for (int k = 0; k < NT; k++) beats[k] = DW'(k + 1);
        run_burst("pre_rst", 1'b0);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        i_coef_valid = 1'b1;
        iv_coef = 24'h0000AA;
        for (int j = 0; j < 3; j++) step();
        #2;
        i_rst = 1'b1;
        #1;
        exp_weights = '0;
        check("midrst weights", ov_weights, exp_weights);
        check("midrst wvalid", W'(o_weights_valid), W'(0));
        check("midrst busy", W'(o_busy), W'(0));
        check("midrst ready", W'(o_coef_ready), W'(0));
        step();
        i_rst = 1'b0;
        step();
        check("midrst stays_idle", W'(o_busy), W'(0));
        check("midrst ready_idle", W'(o_coef_ready), W'(0));
        i_coef_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fir_coef_loader.md
Name: fir_coef_loader

Overview:
- Coefficient writer for the FIR filter tap chain.
- Accepts a burst of NUM_TAPS coefficients over a valid/ready stream and stages them in a shadow bank.
- Commits the whole bank atomically to a flattened weight bus that drives each tap's weight input, so the filter never runs with a mix of old and new coefficients.

Parameters:
- DATA_WIDTH, 24, coefficient width (signed, matches tap data width).
- NUM_TAPS, 8, number of taps/coefficients per burst (>=2).
- IDX_WIDTH, 3, index counter width; must satisfy 2**IDX_WIDTH >= NUM_TAPS.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_start  in  1  request a new load burst.
- i_abort  in  1  cancel the burst in progress.
- iv_coef  in  DATA_WIDTH  signed coefficient beat.
- i_coef_valid  in  1  iv_coef valid.
- o_coef_ready  out  1  loader accepts a beat this cycle.
- o_busy  out  1  high in LOAD or COMMIT.
- o_done  out  1  one-cycle pulse: new weights are visible.
- o_weights_valid  out  1  high once at least one commit has completed since reset.
- ov_weights  out  DATA_WIDTH*NUM_TAPS  active coefficients; tap k at [k*DATA_WIDTH +: DATA_WIDTH].

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, index=0, shadow bank=0, ov_weights=0.
  - o_coef_ready=0, o_busy=0, o_done=0, o_weights_valid=0.
  - Reset mid-burst discards the partial load and zeroes the active weights.
- All outputs are registered. No combinational path exists from inputs to outputs.
- FSM states: IDLE, LOAD, COMMIT.
- IDLE:
  - o_coef_ready=0.
  - i_start=1 -> LOAD, index=0. o_coef_ready=1 from the next cycle.
  - Beats presented in IDLE are ignored.
- LOAD:
  - o_coef_ready=1.
  - A beat transfers on i_coef_valid & o_coef_ready: shadow[index]<=iv_coef, then index++.
  - The beat accepted with index==NUM_TAPS-1 -> COMMIT. o_coef_ready drops the following cycle.
  - Gaps in i_coef_valid are allowed; there is no timeout.
  - i_start in LOAD is ignored; there is no restart.
- COMMIT (exactly one cycle):
  - o_coef_ready=0.
  - On the exiting edge: ov_weights<=shadow, o_done<=1 for one cycle, o_weights_valid<=1, state->IDLE.
  - o_done is high in the first cycle the new ov_weights are visible.
  - i_abort in COMMIT is ignored; the commit completes.
- Abort:
  - i_abort=1 in LOAD -> IDLE next cycle. ov_weights is unchanged and o_done is not pulsed.
  - Abort takes priority over a simultaneous beat; that beat is not accepted. Its stall is masked: o_coef_ready is still 1 in that cycle, so the source must treat abort as flushing the beat.
  - Shadow contents after abort are don't-care.
- Throughput:
  - Minimum burst is NUM_TAPS beats back-to-back.
  - i_start to first possible beat: 1 cycle.
  - Last beat to o_done: 2 cycles (COMMIT, then done visible).
  - A new i_start is accepted in the same cycle o_done is high, since the state is IDLE.
- Width rules:
  - Coefficients are stored verbatim with no sign extension or saturation.
  - Index compares against NUM_TAPS-1 and never wraps past it.
- o_busy = (state != IDLE), registered with the state.

Optional Feature:
- Macro: FIR_COEF_REVERSE_EN.
- Defined:
  - Beat j is written to shadow[NUM_TAPS-1-j].
  - This lets software send h[0..N-1] in natural order while the transposed tap chain receives tap 0 = h[N-1].
- Undefined:
  - Beat j writes shadow[j].
- Handshake, latency and the commit/abort rules are identical in both builds.

Test Plan:
1. Reset/idle:
   - Stimulus: assert i_rst mid-cycle, then release.
   - Response: every output 0 immediately on assert. o_coef_ready stays 0 with i_coef_valid=1 and no i_start.
2. Back-to-back load:
   - Stimulus: NUM_TAPS=8; i_start, then 8 consecutive beats 1,2,...,8 (reverse macro off).
   - Response: ov_weights tap k = k+1. o_done single pulse 2 cycles after the 8th beat. o_weights_valid=1.
3. Gapped load:
   - Stimulus: the same 8 beats with i_coef_valid low every other cycle; values -1 (0xFFFFFF), 0x7FFFFF, -0x800000, ...
   - Response: exact bit patterns stored. ov_weights holds the old values until o_done.
4. Abort:
   - Stimulus: commit 1..8, start a new burst, send 5 beats of 0x100, assert i_abort together with the 6th beat.
   - Response: ov_weights still 1..8. No o_done. Next burst of 0x55 x8 commits correctly from index 0.
5. Reset mid-load:
   - Stimulus: commit 1..8, then send 3 beats and assert i_rst.
   - Response: ov_weights=0, o_weights_valid=0, state IDLE.
6. Reverse build:
   - Stimulus: FIR_COEF_REVERSE_EN defined, beats 1..8.
   - Response: tap 0 = 8, tap 7 = 1. Same cycle timing as test 2.
